// File: rtl/elastic_pipe.sv
// Elastic pipeline: DEPTH register stages with per-stage valid bits, valid/ready at both ends.
// Latency: DEPTH cycles from input handshake to out_valid when the consumer is not stalling.
// Backpressure: a stage advances when it is empty or the stage ahead advances (bubbles squeeze out);
//               out_ready -> in_ready is the only combinational path through the pipe.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     producer handshake, in_data payload
//   flush                 kills every in-flight word at the next edge; blocks both handshakes this cycle
//   out_valid/out_ready   consumer handshake, out_data payload of the last stage
//   occupancy             registered count of valid stages (0..DEPTH)

module elastic_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] ready;
  logic             in_hs;
  logic             out_hs;

  // Unrolled form of ready[k] = !valid[k] | ready[k+1]: a stage may load when the
  // consumer is taking a word or there is a bubble at or downstream of it. Written
  // as a running OR so the vector never feeds back on itself.
  always_comb begin
    logic bubble;
    bubble = 1'b0;
    ready  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      bubble   = bubble | !valid[k];
      ready[k] = out_ready | bubble;
    end
  end

  assign in_ready  = ready[0] & !flush;
  // A flush cycle must not deliver: the word in the last stage dies at this edge.
  assign out_valid = valid[DEPTH-1] & !flush;
  assign out_data  = data[DEPTH-1];

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      occupancy <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data[k] <= '0;
      end
    end else if (flush) begin
      // Payload registers are left as they are; only the valid bits matter.
      valid     <= '0;
      occupancy <= '0;
    end else begin
      if (ready[0]) begin
        valid[0] <= in_valid;
        data[0]  <= in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (ready[k]) begin
          valid[k] <= valid[k-1];
          data[k]  <= data[k-1];
        end
      end
      occupancy <= occupancy + CNT_W'(in_hs) - CNT_W'(out_hs);
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: directed vectors on a DEPTH=4 instance, then a random
// valid/ready run on DEPTH=4 and DEPTH=1 instances against queue scoreboards.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.

module tb_elastic_pipe;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, flush, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [2:0]   occupancy;

  logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [W-1:0] b_in_data, b_out_data;
  logic [0:0]   b_occupancy;

  elastic_pipe #(.WIDTH(W), .DEPTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  elastic_pipe #(.WIDTH(W), .DEPTH(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  logic [W-1:0] a_q[$];
  logic [W-1:0] b_q[$];

  initial begin
    logic        exp_v;
    int          acc, del;
    int unsigned a_acc, a_del, b_acc, b_del;
    logic [31:0] exp_d;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_occ",       occupancy, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_b_out_valid", b_out_valid, 0);
    tick();

    // Stream 1..10 with no back-pressure: word i is presented in cycle i+3.
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      in_valid = (c < 10);
      in_data  = W'(c + 1);
      settle();
      exp_v = (c >= 4 && c <= 13);
      acc   = (c < 10) ? c : 10;
      del   = (c < 4) ? 0 : ((c - 4 > 10) ? 10 : c - 4);
      check("stream_valid", out_valid, 32'(exp_v));
      if (exp_v) check("stream_data", out_data, 32'(c - 3));
      check("stream_occ", occupancy, 32'(acc - del));
      if (c < 10) check("stream_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;

    // Fill under stall, then release with a simultaneous input handshake.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA1 + W'(i);
      settle();
      check("fill_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b1;
    in_data  = 8'hA5;
    settle();
    check("full_in_ready", in_ready,  0);
    check("full_occ",      occupancy, 4);
    check("full_out_data", out_data,  8'hA1);
    #1;
    out_ready = 1'b1;
    #1;
    check("pass_in_ready",  in_ready,  1);
    check("pass_out_valid", out_valid, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (i == 0) check("pass_occ", occupancy, 4);
      check("drain_valid", out_valid, 1);
      check("drain_data",  out_data,  32'(8'hA2 + i));
      tick();
    end
    settle();
    check("drain_empty_valid", out_valid, 0);
    check("drain_empty_occ",   occupancy, 0);
    tick();

    // Bubble squeeze under stall.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1; in_data = 8'h22;
    settle();
    check("bub_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    settle();
    check("bub_occ",       occupancy, 2);
    check("bub_out_valid", out_valid, 1);
    check("bub_out_data",  out_data,  8'h11);
    check("bub_in_ready2", in_ready,  1);
    tick(); tick();
    settle();
    check("bub_hold_occ",  occupancy, 2);
    check("bub_hold_data", out_data,  8'h11);
    out_ready = 1'b1;
    #1;
    check("bub_rel_data", out_data, 8'h11);
    tick();
    settle();
    check("bub_second_valid", out_valid, 1);
    check("bub_second_data",  out_data,  8'h22);
    tick();
    settle();
    check("bub_empty_valid", out_valid, 0);
    check("bub_empty_occ",   occupancy, 0);
    tick();

    // Flush with three words in flight and a word offered in the flush cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h31 + W'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    settle();
    check("preflush_occ",   occupancy, 3);
    check("preflush_valid", out_valid, 1);
    tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b1;
    settle();
    check("flush_in_ready",  in_ready,  0);
    check("flush_out_valid", out_valid, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    settle();
    check("postflush_occ",      occupancy, 0);
    check("postflush_valid",    out_valid, 0);
    check("postflush_in_ready", in_ready,  1);
    tick();
    in_valid = 1'b1; in_data = 8'h55;
    settle();
    check("f55_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      settle();
      check("f55_valid", out_valid, 32'(k == 4));
      if (k == 4) check("f55_data", out_data, 8'h55);
      tick();
    end
    settle();
    check("f55_after_valid", out_valid, 0);
    check("f55_after_occ",   occupancy, 0);
    tick();

    // Reset while full and stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h61 + W'(i);
      tick();
    end
    in_valid = 1'b0;
    settle();
    check("prerst_occ",      occupancy, 4);
    check("prerst_in_ready", in_ready,  0);
    check("prerst_data",     out_data,  8'h61);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data",  out_data,  0);
    check("midrst_occ",       occupancy, 0);
    check("midrst_in_ready",  in_ready,  1);
    tick();

    // Random traffic on both depths against queue scoreboards.
    a_acc = 0; a_del = 0; b_acc = 0; b_del = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid    = ($urandom_range(0, 99) < 70);
      in_data     = W'($urandom);
      out_ready   = ($urandom_range(0, 99) < 60);
      b_in_valid  = ($urandom_range(0, 99) < 60);
      b_in_data   = W'($urandom);
      b_out_ready = ($urandom_range(0, 99) < 60);
      settle();
      check("rnd_occ4", occupancy,   a_acc - a_del);
      check("rnd_occ1", b_occupancy, b_acc - b_del);
      if (out_valid && out_ready) begin
        if (a_q.size() != 0) exp_d = 32'(a_q.pop_front());
        else exp_d = 'x;
        check("rnd_data4", out_data, exp_d);
        a_del++;
      end
      if (in_valid && in_ready) begin
        a_q.push_back(in_data);
        a_acc++;
      end
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() != 0) exp_d = 32'(b_q.pop_front());
        else exp_d = 'x;
        check("rnd_data1", b_out_data, exp_d);
        b_del++;
      end
      if (b_in_valid && b_in_ready) begin
        b_q.push_back(b_in_data);
        b_acc++;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
Name: elastic_pipe

Overview:
- Parameterized multi-stage pipeline register chain, valid/ready handshaked at both ends.
- Sits between a producer stage (fetch/decode output) and a consumer stage (execute input).
- Replaces the free-running shift chain with per-stage valid bits, back-pressure with bubble squeeze, and synchronous flush for branch/exception recovery.
- Also reports live occupancy to hazard logic.

Parameters:
- WIDTH, 8, payload width in bits.
- DEPTH, 4, number of register stages; legal range 1..7.
- CNT_W, 3, occupancy counter width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  pipe accepts a word this cycle (combinational).
- in_data  input  WIDTH  producer payload.
- flush  input  1  synchronous kill of all in-flight words.
- out_valid  output  1  stage DEPTH-1 holds a valid word.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  WIDTH  payload of stage DEPTH-1.
- occupancy  output  CNT_W  registered count of valid stages, 0..DEPTH.

Behaviour:
- Reset is synchronous and active-high. Clock `clk`, reset `rst`. Single clock, no async paths.
- **Reset state:** all stage valid bits 0, all stage data registers 0, occupancy 0. Consequently out_valid=0 and out_data=0 after the reset edge.
- **Stage indexing:** stage 0 is nearest the input; stage DEPTH-1 drives the outputs.
- **Ready chain (combinational):**
  - ready[DEPTH] = out_ready.
  - ready[k] = !valid[k] | ready[k+1].
  - in_ready = ready[0] & !flush.
- **Load rule, per stage k:**
  - On a clock edge with ready[k]=1, stage k loads valid and data from stage k-1 (stage 0 loads from in_valid/in_data).
  - Otherwise stage k holds both valid and data.
  - When a stage loads an invalid word, its data register still loads (don't-care payload); only valid is significant.
- **Bubble squeeze:** an invalid stage accepts new data even while out_ready=0, so bubbles close up under back-pressure.
- **Handshakes:**
  - Input handshake = in_valid & in_ready.
  - Output handshake = out_valid & out_ready.
  - Input data is not required to stay stable while in_ready=0, but producers hold it by convention.
- **Latency:** with no back-pressure, a word accepted at edge E is presented (out_valid=1) after edge E+DEPTH-1, i.e. DEPTH cycles from its input handshake cycle.
- **Throughput:** 1 word/cycle sustained when out_ready=1 continuously.
- **Ordering:** words exit strictly in acceptance order. No duplication, no loss except by flush.
- **Flush:**
  - Flush has priority over all loads.
  - At the edge where flush=1, every valid bit clears and occupancy goes to 0. Data registers are left unchanged.
  - In the flush cycle, in_ready=0 and out_valid is forced to 0. No handshake can occur that cycle, so a word presented then is neither accepted nor delivered.
  - Normal operation resumes the next cycle.
- **Occupancy update:**
  - occupancy_next = occupancy + in_hs − out_hs.
  - Simultaneous input and output handshakes leave it unchanged.
  - Flush forces 0; rst forces 0.
  - occupancy never exceeds DEPTH and never underflows.
- **Full:** all DEPTH stages valid and out_ready=0 gives in_ready=0. If out_ready rises, in_ready rises in the same cycle (combinational pass-through), so a full pipe streams without a lost cycle.
- **Empty:** occupancy=0 gives out_valid=0; in_ready=1 unless flush is asserted.
- **Reset mid-operation:** rst overrides flush and the load rules. All state returns to reset values at that edge and in-flight words are discarded.
- **No combinational path** from in_valid/in_data to out_valid/out_data. The only combinational path is out_ready → in_ready.

Test Plan:
- Reset then stream 1,2,3,...,10 with out_ready=1: first out_valid after the 4th edge following acceptance of 1; outputs 1..10 in order, one per cycle; occupancy steady at 4.
- Fill 4 words (0xA1..0xA4) with out_ready=0: in_ready drops to 0 after the 4th accept and occupancy=4. Then raise out_ready with in_valid=1 and data 0xA5: 0xA1 exits and 0xA5 is accepted in the same cycle, occupancy stays 4.
- Bubble squeeze: send 0x11, idle 2 cycles, send 0x22, hold out_ready=0: both words advance until stages 3 and 2 are valid; occupancy=2; in_ready remains 1.
- Flush with 3 words in flight and in_valid=1 in the flush cycle: in_ready=0 and out_valid=0 that cycle; the next cycle occupancy=0 and out_valid=0; the presented word is not accepted; subsequent word 0x55 emerges after 4 cycles.
- Assert rst for 1 cycle while full and stalled: the next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Random in_valid/out_ready (10k cycles, WIDTH=8, DEPTH=4 and DEPTH=1): a scoreboard confirms in-order, lossless delivery, and that occupancy always equals accepted minus delivered words.
